// File: rtl/board_input_ctrl_if.sv
// Front-panel bus between the raw board inputs and the conditioned outputs
// that feed the CPU wrapper and the display mux.
interface board_input_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic              go;
   logic              addrI;
   logic              hFreq;
   logic [2:0]        dataSel;
   logic              go_pulse;
   logic              addr_step;
   logic [ADDR_W-1:0] memAddr;
   logic              hfreq_q;
   logic [2:0]        sel_q;

   // The panel side drives raw buttons/switches and watches the clean results
   modport master (
      output go, addrI, hFreq, dataSel,
      input  go_pulse, addr_step, memAddr, hfreq_q, sel_q
   );

   // The conditioner consumes raw inputs and produces the clean results
   modport slave (
      input  go, addrI, hFreq, dataSel,
      output go_pulse, addr_step, memAddr, hfreq_q, sel_q
   );
endinterface

// File: rtl/board_input_ctrl.sv
// Front-panel input conditioner: synchronises and debounces the go / addrI
// buttons and the hFreq / dataSel switches, produces one-cycle press pulses,
// filtered switch levels and the memory-inspection address with auto-repeat.
module board_input_ctrl #(
   parameter int ADDR_W          = 10,
   parameter int ADDR_MAX        = 1023,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int HOLD_CYCLES     = 167,
   parameter int REPEAT_CYCLES   = 33
) (
   input logic                clk,
   input logic                rst,
   board_input_ctrl_if.slave  bus
);

   localparam int CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

   localparam logic [CNT_W-1:0]  DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(ADDR_MAX);

   typedef enum logic [1:0] {
      BTN_IDLE,
      BTN_ARM,
      BTN_PRESSED,
      BTN_REL
   } btn_state_t;

   logic [5:0] raw_in;
   logic [5:0] sync_a;
   logic [5:0] sync_b;
   logic [1:0] btn_s;
   logic [3:0] lvl_s;

   btn_state_t       btn_state    [2];
   btn_state_t       btn_next     [2];
   logic [CNT_W-1:0] btn_cnt      [2];
   logic [CNT_W-1:0] btn_cnt_next [2];
   logic [1:0]       btn_accept;

   logic [HOLD_W-1:0] hold_cnt;
   logic              repeating;
   logic              hold_done;
   logic              repeat_tick;

   logic [3:0]       lvl_q;
   logic [3:0]       lvl_next;
   logic [CNT_W-1:0] lvl_cnt      [4];
   logic [CNT_W-1:0] lvl_cnt_next [4];

   logic              go_pulse_q;
   logic              addr_step_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              step_req;
   logic              sel_clear;

   // Bit order: [0]=go, [1]=addrI, [2]=hFreq, [5:3]=dataSel
   assign raw_in = {bus.dataSel, bus.hFreq, bus.addrI, bus.go};
   assign btn_s  = sync_b[1:0];
   assign lvl_s  = sync_b[5:2];

   // Two-flop synchroniser for every raw input; also keeps a button held across
   // reset release from being seen for two cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= raw_in;
         sync_b <= sync_a;
      end
   end

   // Button debounce next-state: a press is accepted only after the synced
   // input has stayed high through ARM, and release must stay low through REL
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         btn_next[i]     = btn_state[i];
         btn_cnt_next[i] = btn_cnt[i];
         btn_accept[i]   = 1'b0;
         case (btn_state[i])
            BTN_IDLE: begin
               if (btn_s[i]) begin
                  btn_next[i]     = BTN_ARM;
                  btn_cnt_next[i] = CNT_ONE;
               end
            end
            BTN_ARM: begin
               if (!btn_s[i]) begin
                  btn_next[i]     = BTN_IDLE;
                  btn_cnt_next[i] = '0;
               end else if (btn_cnt[i] == DEB_LAST) begin
                  btn_next[i]     = BTN_PRESSED;
                  btn_cnt_next[i] = '0;
                  btn_accept[i]   = 1'b1;
               end else begin
                  btn_cnt_next[i] = btn_cnt[i] + CNT_ONE;
               end
            end
            BTN_PRESSED: begin
               if (!btn_s[i]) begin
                  btn_next[i]     = BTN_REL;
                  btn_cnt_next[i] = CNT_ONE;
               end
            end
            BTN_REL: begin
               if (btn_s[i]) begin
                  btn_next[i]     = BTN_PRESSED;
                  btn_cnt_next[i] = '0;
               end else if (btn_cnt[i] == DEB_LAST) begin
                  btn_next[i]     = BTN_IDLE;
                  btn_cnt_next[i] = '0;
               end else begin
                  btn_cnt_next[i] = btn_cnt[i] + CNT_ONE;
               end
            end
            default: begin
               btn_next[i]     = BTN_IDLE;
               btn_cnt_next[i] = '0;
            end
         endcase
      end
   end

   // Button state and debounce counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            btn_state[i] <= BTN_IDLE;
            btn_cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            btn_state[i] <= btn_next[i];
            btn_cnt[i]   <= btn_cnt_next[i];
         end
      end
   end

   // Auto-repeat fires once the hold interval has elapsed, then at the repeat interval
   always_comb begin
      hold_done   = repeating ? (hold_cnt == REPEAT_LAST) : (hold_cnt == HOLD_LAST);
      repeat_tick = (btn_state[1] == BTN_PRESSED) && btn_s[1] && hold_done;
   end

   // addrI hold counter: runs only while pressed, frozen during release bounce,
   // cleared once the button is back in IDLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt  <= '0;
         repeating <= 1'b0;
      end else if (btn_state[1] == BTN_IDLE) begin
         hold_cnt  <= '0;
         repeating <= 1'b0;
      end else if ((btn_state[1] == BTN_PRESSED) && btn_s[1]) begin
         if (hold_done) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   // Level filters: each switch bit adopts the synced value after it has
   // differed from the output for the full debounce window without a break
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lvl_next[i]     = lvl_q[i];
         lvl_cnt_next[i] = '0;
         if (lvl_s[i] != lvl_q[i]) begin
            if (lvl_cnt[i] == DEB_LAST) begin
               lvl_next[i] = lvl_s[i];
            end else begin
               lvl_cnt_next[i] = lvl_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // Level filter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lvl_q <= '0;
         for (int i = 0; i < 4; i++) begin
            lvl_cnt[i] <= '0;
         end
      end else begin
         lvl_q <= lvl_next;
         for (int i = 0; i < 4; i++) begin
            lvl_cnt[i] <= lvl_cnt_next[i];
         end
      end
   end

   // Clear uses the incoming dataSel[2] level so a clear landing on the same
   // edge as a step request wins and the outputs stay mutually consistent
   assign step_req  = btn_accept[1] | repeat_tick;
   assign sel_clear = ~lvl_next[3];

   // Press pulse and memory-inspection address with wrap at ADDR_MAX
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         go_pulse_q  <= 1'b0;
         addr_step_q <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         go_pulse_q  <= btn_accept[0];
         addr_step_q <= 1'b0;
         if (sel_clear) begin
            mem_addr_q <= '0;
         end else if (step_req) begin
            mem_addr_q  <= (mem_addr_q == ADDR_LAST) ? '0 : mem_addr_q + 1'b1;
            addr_step_q <= 1'b1;
         end
      end
   end

   assign bus.go_pulse  = go_pulse_q;
   assign bus.addr_step = addr_step_q;
   assign bus.memAddr   = mem_addr_q;
   assign bus.hfreq_q   = lvl_q[0];
   assign bus.sel_q     = lvl_q[3:1];

endmodule
